// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//   Shares the single-port data memory between the processor core (load/store
//   path) and a host/loader port. The core normally has priority. A starvation
//   counter forces a host grant after STARVE_MAX consecutive denied host
//   cycles. A granted host access with host_lock set moves the arbiter into
//   LOCKED, where the host owns the memory exclusively until host_lock drops.
//
//   Grants, stalls and the memory drive are combinational (zero latency). Host
//   read data is registered and returned one cycle after the read grant.
//
// Ports
//   clk, reset                  clock, synchronous active-high reset
//   core_req/we/addr/wdata      core access request
//   core_stall, core_rdata      core not serviced / load data (same cycle)
//   host_req/we/addr/wdata      host access request
//   host_lock                   exclusive ownership request (with a grant)
//   host_gnt                    host access performed this cycle
//   host_rvalid, host_rdata     registered host read return
//   mem_wr_en/addr/dat_in       drive to the data memory
//   mem_dat_out                 combinational read data from the memory
//
// Configuration
//   DMEM_ARB_STATS_EN  adds saturating 16-bit counters stat_core_gnt,
//                      stat_host_gnt and stat_conflict.
// -----------------------------------------------------------------------------
module dmem_arbiter #(
    parameter int AW         = 8,
    parameter int DW         = 8,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          core_req,
    input  logic          core_we,
    input  logic [AW-1:0] core_addr,
    input  logic [DW-1:0] core_wdata,
    output logic          core_stall,
    output logic [DW-1:0] core_rdata,
    input  logic          host_req,
    input  logic          host_we,
    input  logic [AW-1:0] host_addr,
    input  logic [DW-1:0] host_wdata,
    input  logic          host_lock,
    output logic          host_gnt,
    output logic          host_rvalid,
    output logic [DW-1:0] host_rdata,
`ifdef DMEM_ARB_STATS_EN
    output logic [15:0]   stat_core_gnt,
    output logic [15:0]   stat_host_gnt,
    output logic [15:0]   stat_conflict,
`endif
    output logic          mem_wr_en,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_dat_in,
    input  logic [DW-1:0] mem_dat_out
);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    logic [0:0] state;
    logic [3:0] starve_cnt;
    logic       core_win;
    logic       host_win;
    logic       wr_sel;

    // Grant decision: LOCKED serves only the host; IDLE lets the core win a
    // conflict unless the host has been denied STARVE_MAX cycles in a row.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        core_win   = 1'b0;
        host_win   = 1'b0;
        mem_addr   = '0;
        mem_dat_in = '0;
        wr_sel     = 1'b0;
        if (state == ST_LOCKED) begin
            host_win = host_req;
        end else if (host_req && (!core_req || starve_cnt == STARVE_LIM)) begin
            host_win = 1'b1;
        end else begin
            core_win = core_req;
        end
        if (core_win) begin
            mem_addr   = core_addr;
            mem_dat_in = core_wdata;
            wr_sel     = core_we;
        end else if (host_win) begin
            mem_addr   = host_addr;
            mem_dat_in = host_wdata;
            wr_sel     = host_we;
        end
    end

    assign core_stall = core_req & ~core_win;
    assign host_gnt   = host_win;
    assign core_rdata = mem_dat_out;
    // The write of a reset cycle is dropped; everything else follows inputs.
    assign mem_wr_en  = wr_sel & ~reset;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            starve_cnt  <= '0;
            host_rvalid <= 1'b0;
            host_rdata  <= '0;
        end else begin
            if (state == ST_IDLE) begin
                if (host_win && host_lock) state <= ST_LOCKED;
            end else if (!host_lock) begin
                state <= ST_IDLE;
            end

            if (host_req && !host_win) begin
                if (starve_cnt != STARVE_LIM) starve_cnt <= starve_cnt + 4'd1;
            end else begin
                starve_cnt <= '0;
            end

            host_rvalid <= host_win & ~host_we;
            if (host_win && !host_we) host_rdata <= mem_dat_out;
        end
    end

`ifdef DMEM_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_core_gnt <= '0;
            stat_host_gnt <= '0;
            stat_conflict <= '0;
        end else begin
            if (core_win && stat_core_gnt != 16'hFFFF)
                stat_core_gnt <= stat_core_gnt + 16'd1;
            if (host_win && stat_host_gnt != 16'hFFFF)
                stat_host_gnt <= stat_host_gnt + 16'd1;
            if (core_req && host_req && stat_conflict != 16'hFFFF)
                stat_conflict <= stat_conflict + 16'd1;
        end
    end
`endif

endmodule
